// File: rtl/dbg_uart_defs.sv
// Shared definitions for the register-dump UART path: FSM encodings,
// frame geometry and the default baud divider.
package dbg_uart_defs;

    // Dump FSM encodings (kept as plain constants for legacy tool flows)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETADDR = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;

    // One header byte (register index) followed by four data bytes, MSB first
    localparam int BYTES_PER_REG    = 5;
    localparam int UART_DATA_BITS   = 8;
    // 100 MHz / 115200 baud
    localparam int DEF_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART 8N1 transmitter with a VALID/READY input handshake.
// READY drops on acceptance and returns when the stop bit has been held
// for its full bit time; TX idles high.
module uart_tx_byte
    import dbg_uart_defs::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] DATA,
    input  logic       VALID,
    output logic       READY,
    output logic       TX
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // bit_q walks 0 = start, 1..8 = data, 9 = stop
    localparam logic [3:0] BIT_LAST_DATA = 4'(UART_DATA_BITS);
    localparam logic [3:0] BIT_STOP      = 4'(UART_DATA_BITS + 1);

    logic             busy_q,  busy_d;
    logic             tx_q,    tx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       bit_q,   bit_d;
    logic [CNT_W-1:0] baud_q,  baud_d;

    assign READY = ~busy_q;
    assign TX    = tx_q;

    // Next-state: latch a byte on handshake, then step one bit per baud period
    always_comb begin
        busy_d  = busy_q;
        tx_d    = tx_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        if (!busy_q) begin
            if (VALID) begin
                busy_d  = 1'b1;
                tx_d    = 1'b0;
                shreg_d = DATA;
                bit_d   = 4'd0;
                baud_d  = '0;
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            bit_d  = bit_q + 4'd1;
            if (bit_q == BIT_STOP) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else if (bit_q == BIT_LAST_DATA) begin
                tx_d = 1'b1;
            end else begin
                tx_d    = shreg_q[0];
                shreg_d = {1'b0, shreg_q[7:1]};
            end
        end else begin
            baud_d = baud_q + CNT_W'(1);
        end
    end

    // State registers; active-low synchronous reset returns the line to idle
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
            shreg_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            tx_q    <= tx_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
        end
    end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Register-file dump engine: walks the debug read port over every register,
// snapshots each 32-bit value and streams {index, data[31:0]} bytes over UART.
module reg_dump_uart_tx
    import dbg_uart_defs::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic [ADDR_W-1:0] DEBUG_ADDR,
    input  logic [31:0]       DEBUG_DATA,
    output logic              TX,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [2:0]        LAST_BYTE = 3'(BYTES_PER_REG - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic [2:0]        byte_q,  byte_d;
    logic [31:0]       snap_q,  snap_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              tx_ready;

    assign DEBUG_ADDR = addr_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign tx_valid   = (state_q == ST_SEND);

    // Frame byte select: header carries the register index, then snapshot MSB first
    always_comb begin
        tx_byte = 8'h00;
        case (byte_q)
            3'd0:    tx_byte = 8'(idx_q);
            3'd1:    tx_byte = snap_q[31:24];
            3'd2:    tx_byte = snap_q[23:16];
            3'd3:    tx_byte = snap_q[15:8];
            default: tx_byte = snap_q[7:0];
        endcase
    end

    // Dump sequencer. The next register is fetched while the previous frame's
    // last byte is still on the wire, keeping inter-byte gaps within 1..4 clocks.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        snap_d  = snap_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A START coinciding with the DONE pulse is deliberately dropped
                if (START && !done_q) begin
                    state_d = ST_SETADDR;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            ST_SETADDR: begin
                addr_d  = idx_q;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Whole-register snapshot so a CPU write mid-frame cannot tear it
                snap_d  = DEBUG_DATA;
                byte_d  = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (byte_q == LAST_BYTE && idx_q != LAST_IDX) begin
                    state_d = ST_NEXT;
                end else if (tx_ready) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_NEXT: begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = ST_SETADDR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any dump in progress
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            byte_q  <= '0;
            snap_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            snap_q  <= snap_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .CLK  (CLK),
        .RESET(RESET),
        .DATA (tx_byte),
        .VALID(tx_valid),
        .READY(tx_ready),
        .TX   (TX)
    );

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Bench for reg_dump_uart_tx: a combinational register-file model feeds
// DEBUG_DATA, a UART decoder checks bit timing and pops a byte scoreboard.
module tb_reg_dump_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic [4:0]  addr, addr_s;
    logic [31:0] data, data_s;
    logic        tx, tx_s, busy, busy_s, done, done_s;

    logic [31:0] regs [32];
    logic        sel = 1'b0;
    logic        in_reset = 1'b0;

    int n_total = 0;
    int n_bad   = 0;
    int rx_cnt  = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_stop_cyc = 0;
    int cyc = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign data   = regs[addr];
    assign data_s = regs[addr_s];

    logic mon_tx, mon_busy, mon_done;
    logic [4:0] mon_addr;
    assign mon_tx   = sel ? tx_s   : tx;
    assign mon_busy = sel ? busy_s : busy;
    assign mon_done = sel ? done_s : done;
    assign mon_addr = sel ? addr_s : addr;

    reg_dump_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(32), .ADDR_W(5)) dut (
        .CLK(clk), .RESET(rst_n), .START(start), .DEBUG_ADDR(addr),
        .DEBUG_DATA(data), .TX(tx), .BUSY(busy), .DONE(done)
    );

    reg_dump_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_REGS(4), .ADDR_W(5)) dut_small (
        .CLK(clk), .RESET(rst_n), .START(start_s), .DEBUG_ADDR(addr_s),
        .DEBUG_DATA(data_s), .TX(tx_s), .BUSY(busy_s), .DONE(done_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART decoder: every cycle of every bit is sampled, then the byte is scored
    initial begin : monitor
        logic [7:0]  v;
        logic        ok;
        logic        ab;
        logic        have_prev;
        logic [31:0] e;
        int          gap;
        int          b;
        have_prev = 1'b0;
        gap = 0;
        forever begin
            @(negedge clk);
            if (in_reset || mon_busy !== 1'b1) begin
                have_prev = 1'b0;
                gap = 0;
            end else if (mon_tx === 1'b0) begin
                if (have_prev) chk("gap_1_to_4", 32'(gap >= 1 && gap <= 4), 32'd1);
                ok = 1'b1; ab = 1'b0; v = 8'h00;
                for (int c = 1; c < 10 * CPB; c++) begin
                    @(negedge clk);
                    if (in_reset) ab = 1'b1;
                    b = c / CPB;
                    if (b == 0) begin
                        if (mon_tx !== 1'b0) ok = 1'b0;
                    end else if (b <= 8) begin
                        if (c % CPB == 0) v[b-1] = mon_tx;
                        else if (mon_tx !== v[b-1]) ok = 1'b0;
                    end else begin
                        if (mon_tx !== 1'b1) ok = 1'b0;
                    end
                end
                last_stop_cyc = cyc;
                if (!ab) begin
                    chk("bit_timing", {31'd0, ok}, 32'd1);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
                    chk("rx_byte", {24'd0, v}, e);
                    $display("byte %0d: rx=%02h exp=%0h", rx_cnt, v, e);
                    rx_cnt++;
                    have_prev = 1'b1;
                end else begin
                    have_prev = 1'b0;
                end
                gap = 0;
            end else begin
                gap++;
            end
        end
    end

    // DONE pulse counter; BUSY must fall together with DONE
    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (mon_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_with_done", {31'd0, mon_busy}, 32'd0);
            end
        end
    end

    task automatic set_start(input logic v);
        if (sel) start_s = v;
        else     start   = v;
    endtask

    task automatic do_dump(input int nregs, input int restart_at, input int reset_at,
                           input int change_at);
        int budget;
        bit restarted;
        for (int r = 0; r < nregs; r++) begin
            exp_q.push_back(32'(r));
            exp_q.push_back({24'd0, regs[r][31:24]});
            exp_q.push_back({24'd0, regs[r][23:16]});
            exp_q.push_back({24'd0, regs[r][15:8]});
            exp_q.push_back({24'd0, regs[r][7:0]});
        end
        rx_cnt = 0;
        done_cnt = 0;
        @(negedge clk); set_start(1'b1);
        @(negedge clk); set_start(1'b0);
        chk("busy_after_start", {31'd0, mon_busy}, 32'd1);
        budget = 0;
        restarted = 1'b0;
        while (mon_busy === 1'b1 && budget < 12000) begin
            @(negedge clk);
            budget++;
            if (!restarted && restart_at >= 0 && rx_cnt == restart_at) begin
                set_start(1'b1);
                @(negedge clk);
                set_start(1'b0);
                restarted = 1'b1;
            end
            if (change_at >= 0 && rx_cnt == change_at) regs[3] = 32'h22222222;
            if (reset_at >= 0 && rx_cnt == reset_at) begin
                repeat (12) @(negedge clk);
                in_reset = 1'b1;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk("rst_mid_tx", {31'd0, mon_tx}, 32'd1);
                chk("rst_mid_busy", {31'd0, mon_busy}, 32'd0);
                chk("rst_mid_addr", {27'd0, mon_addr}, 32'd0);
                chk("rst_mid_done", {31'd0, mon_done}, 32'd0);
                exp_q.delete();
                repeat (200) @(negedge clk);
                chk("rst_no_done", 32'(done_cnt), 32'd0);
                chk("rst_tx_idle", {31'd0, mon_tx}, 32'd1);
                in_reset = 1'b0;
                return;
            end
        end
        chk("dump_in_budget", 32'(budget < 12000), 32'd1);
        chk("done_at_busy_fall", {31'd0, mon_done}, 32'd1);
        // START in the DONE cycle must not begin another dump
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        chk("start_on_done_ignored", {31'd0, mon_busy}, 32'd0);
        repeat (10) @(negedge clk);
        chk("byte_count", 32'(rx_cnt), 32'(nregs * 5));
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("addr_final", {27'd0, mon_addr}, 32'(nregs - 1));
        chk("done_after_stop", 32'(done_cyc - last_stop_cyc), 32'd2);
        chk("idle_busy", {31'd0, mon_busy}, 32'd0);
    endtask

    initial begin : stim
        for (int r = 0; r < 32; r++) regs[r] = 32'hA5000000 | 32'(r);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_addr", {27'd0, addr}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Full dump of the default pattern
        do_dump(32, -1, -1, -1);

        // Snapshot integrity plus a START re-pulse mid-dump
        regs[3] = 32'h11111111;
        do_dump(32, 50, -1, 17);
        regs[3] = 32'hA5000003;

        // Reset during byte 70 aborts, then a clean dump follows
        do_dump(32, -1, 70, -1);
        repeat (5) @(negedge clk);
        do_dump(32, -1, -1, -1);

        // Four-register instance
        sel = 1'b1;
        repeat (5) @(negedge clk);
        do_dump(4, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
